// File: rtl/mcb_pkg.sv
// Shared encodings for the MCB user-port responder: command instructions and FSM states.
package mcb_pkg;

   localparam logic [2:0] MCB_WR      = 3'b000;
   localparam logic [2:0] MCB_RD      = 3'b001;
   localparam int         MCB_REF_BIT = 2;

   typedef enum logic [2:0] {
      ST_CALIB,
      ST_IDLE,
      ST_WRITE,
      ST_RWAIT,
      ST_READ
   } mcb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  pop_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem [2**AW];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(2**AW));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // head is forced to zero while empty so the output is defined out of reset
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mcb_port_responder.sv
// BRAM-backed stand-in for the MCB p0 user port: single command slot, wr/rd FIFOs,
// calibration delay and a serialising command FSM in front of a byte-lane array.
module mcb_port_responder #(
   parameter int ADDR_W       = 10,
   parameter int FIFO_AW      = 6,
   parameter int CALIB_CYCLES = 16,
   parameter int RD_LATENCY   = 4
) (
   input  logic               clk,
   input  logic               reset,
   output logic               calib_done,
   input  logic               cmd_en,
   input  logic [2:0]         cmd_instr,
   input  logic [5:0]         cmd_bl,
   input  logic [29:0]        cmd_byte_addr,
   output logic               cmd_empty,
   output logic               cmd_full,
   input  logic               wr_en,
   input  logic [15:0]        wr_mask,
   input  logic [127:0]       wr_data,
   output logic               wr_full,
   output logic               wr_empty,
   output logic [FIFO_AW:0]   wr_count,
   output logic               wr_underrun,
   output logic               wr_error,
   input  logic               rd_en,
   output logic [127:0]       rd_data,
   output logic               rd_full,
   output logic               rd_empty,
   output logic [FIFO_AW:0]   rd_count,
   output logic               rd_overflow,
   output logic               rd_error
);
   import mcb_pkg::*;

   localparam int CALW = $clog2(CALIB_CYCLES + 1);
   localparam int LATW = $clog2(RD_LATENCY + 1);
   localparam int SPW  = FIFO_AW + 2;

   mcb_state_e         state, state_nx;
   logic [CALW-1:0]    calib_cnt;
   logic [LATW-1:0]    lat_cnt;
   logic               slot_full;
   logic [2:0]         slot_instr;
   logic [5:0]         slot_bl;
   logic [ADDR_W-1:0]  slot_addr;
   logic [5:0]         bl_q;
   logic [5:0]         idx_q;
   logic [ADDR_W-1:0]  base_q;
   logic [ADDR_W-1:0]  cur_addr;
   logic               take_cmd;
   logic               wr_pop;
   logic               rd_issue;
   logic               rd_pend;
   logic [127:0]       rd_word_q;
   logic [143:0]       wr_head;
   logic               lat_done;
   logic               space_ok;
   logic [SPW-1:0]     rd_used;
   logic [127:0]       mem [2**ADDR_W];
   logic               unused_bits;

   assign unused_bits = ^{cmd_instr[1], cmd_byte_addr[29:ADDR_W+4], cmd_byte_addr[3:0]};

   assign calib_done = (state != ST_CALIB);
   assign cmd_full   = slot_full;
   assign cmd_empty  = !slot_full;
   assign cur_addr   = base_q + ADDR_W'(idx_q);
   assign lat_done   = (lat_cnt >= LATW'(RD_LATENCY - 1));

   // a word still in the array pipeline already owns a FIFO slot
   assign rd_used  = SPW'(rd_count) + SPW'(rd_pend);
   assign space_ok = (SPW'(2**FIFO_AW) - rd_used) >= (SPW'(bl_q) + SPW'(1));

   always_comb begin
      state_nx = state;
      take_cmd = 1'b0;
      wr_pop   = 1'b0;
      rd_issue = 1'b0;
      case (state)
         ST_CALIB: if (calib_cnt == CALW'(CALIB_CYCLES - 1)) state_nx = ST_IDLE;
         ST_IDLE: begin
            if (slot_full) begin
               take_cmd = 1'b1;
               if (slot_instr[MCB_REF_BIT])          state_nx = ST_IDLE;
               else if (slot_instr[0] == MCB_RD[0])  state_nx = ST_RWAIT;
               else                                  state_nx = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (!wr_empty) begin
               wr_pop = 1'b1;
               if (idx_q == bl_q) state_nx = ST_IDLE;
            end
         end
         ST_RWAIT: if (lat_done && space_ok) state_nx = ST_READ;
         ST_READ: begin
            rd_issue = 1'b1;
            if (idx_q == bl_q) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_CALIB;
         calib_cnt   <= '0;
         lat_cnt     <= '0;
         slot_full   <= 1'b0;
         slot_instr  <= '0;
         slot_bl     <= '0;
         slot_addr   <= '0;
         bl_q        <= '0;
         idx_q       <= '0;
         base_q      <= '0;
         rd_pend     <= 1'b0;
         wr_underrun <= 1'b0;
         wr_error    <= 1'b0;
         rd_overflow <= 1'b0;
         rd_error    <= 1'b0;
      end else begin
         state   <= state_nx;
         rd_pend <= rd_issue;
         if (state == ST_CALIB) calib_cnt <= calib_cnt + 1'b1;

         if (take_cmd) begin
            slot_full <= 1'b0;
            bl_q      <= slot_bl;
            base_q    <= slot_addr;
            idx_q     <= '0;
            lat_cnt   <= '0;
         end else begin
            if (cmd_en && !slot_full) begin
               slot_full  <= 1'b1;
               slot_instr <= cmd_instr;
               slot_bl    <= cmd_bl;
               slot_addr  <= cmd_byte_addr[ADDR_W+3:4];
            end
            if (wr_pop || rd_issue) idx_q <= idx_q + 1'b1;
            if (state == ST_RWAIT && !lat_done) lat_cnt <= lat_cnt + 1'b1;
         end

         wr_underrun <= wr_underrun | (state == ST_WRITE && wr_empty);
         wr_error    <= wr_error | (wr_en && wr_full);
         rd_error    <= rd_error | (rd_en && rd_empty);
         rd_overflow <= rd_overflow | (rd_pend && rd_full);
      end
   end

   // single-port array: WRITE and READ never overlap, so one address serves both
   always_ff @(posedge clk) begin
      if (wr_pop) begin
         for (int unsigned b = 0; b < 16; b++) begin
            if (!wr_head[128 + b]) mem[cur_addr][b*8 +: 8] <= wr_head[b*8 +: 8];
         end
      end
      rd_word_q <= mem[cur_addr];
   end

   sync_fifo #(.W(144), .AW(FIFO_AW)) u_wr_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_en),
      .push_data ({wr_mask, wr_data}),
      .pop       (wr_pop),
      .pop_data  (wr_head),
      .full      (wr_full),
      .empty     (wr_empty),
      .count     (wr_count)
   );

   sync_fifo #(.W(128), .AW(FIFO_AW)) u_rd_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rd_pend),
      .push_data (rd_word_q),
      .pop       (rd_en),
      .pop_data  (rd_data),
      .full      (rd_full),
      .empty     (rd_empty),
      .count     (rd_count)
   );

endmodule

// File: tb/tb_mcb_port_responder.sv
// Directed bench for mcb_port_responder: shadow array model plus expected-read queue.
module tb_mcb_port_responder;
   import mcb_pkg::*;

   logic          clk = 1'b0;
   logic          reset;
   logic          calib_done;
   logic          cmd_en;
   logic [2:0]    cmd_instr;
   logic [5:0]    cmd_bl;
   logic [29:0]   cmd_byte_addr;
   logic          cmd_empty, cmd_full;
   logic          wr_en;
   logic [15:0]   wr_mask;
   logic [127:0]  wr_data;
   logic          wr_full, wr_empty, wr_underrun, wr_error;
   logic [6:0]    wr_count;
   logic          rd_en;
   logic [127:0]  rd_data;
   logic          rd_full, rd_empty, rd_overflow, rd_error;
   logic [6:0]    rd_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [127:0] d;
      logic [15:0]  m;
   } wr_t;

   wr_t          wr_pend[$];
   logic [127:0] exp_q[$];
   logic [127:0] model [1024];

   mcb_port_responder #(
      .ADDR_W(10), .FIFO_AW(6), .CALIB_CYCLES(16), .RD_LATENCY(4)
   ) dut (
      .clk(clk), .reset(reset), .calib_done(calib_done),
      .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
      .cmd_byte_addr(cmd_byte_addr), .cmd_empty(cmd_empty), .cmd_full(cmd_full),
      .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
      .wr_full(wr_full), .wr_empty(wr_empty), .wr_count(wr_count),
      .wr_underrun(wr_underrun), .wr_error(wr_error),
      .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty),
      .rd_count(rd_count), .rd_overflow(rd_overflow), .rd_error(rd_error)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_wr(input logic [127:0] d, input logic [15:0] m);
      wr_en   = 1'b1;
      wr_data = d;
      wr_mask = m;
      tick();
      wr_en   = 1'b0;
      wr_pend.push_back({d, m});
   endtask

   task automatic send_cmd(input logic [2:0] instr, input int unsigned bl, input logic [29:0] baddr);
      int n = 0;
      while (!cmd_empty && n < 300) begin
         tick();
         n++;
      end
      check("cmd_slot_free", cmd_empty, 1'b1);
      cmd_en        = 1'b1;
      cmd_instr     = instr;
      cmd_bl        = 6'(bl);
      cmd_byte_addr = baddr;
      tick();
      cmd_en = 1'b0;
   endtask

   function automatic logic [29:0] baddr_of(input int unsigned word);
      return 30'(word * 16);
   endfunction

   task automatic apply_write(input int unsigned word, input int unsigned bl);
      wr_t e;
      for (int unsigned i = 0; i <= bl; i++) begin
         e = wr_pend.pop_front();
         for (int unsigned b = 0; b < 16; b++)
            if (!e.m[b]) model[(word + i) % 1024][b*8 +: 8] = e.d[b*8 +: 8];
      end
   endtask

   task automatic expect_read(input int unsigned word, input int unsigned bl);
      for (int unsigned i = 0; i <= bl; i++) exp_q.push_back(model[(word + i) % 1024]);
   endtask

   task automatic wait_wr_done();
      int n = 0;
      while (!(wr_empty && cmd_empty) && n < 500) begin
         tick();
         n++;
      end
      check("wr_burst_done", wr_empty && cmd_empty, 1'b1);
      repeat (3) tick();
   endtask

   task automatic pop_one(input string tag);
      int n = 0;
      logic [127:0] e;
      while (rd_empty && n < 500) begin
         tick();
         n++;
      end
      check({tag, "_avail"}, rd_empty, 1'b0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      check(tag, rd_data, e);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) pop_one(tag);
   endtask

   task automatic wait_calib(input string tag);
      int n = 0;
      while (!calib_done && n < 100) begin
         tick();
         n++;
      end
      check(tag, 128'(n), 128'd16);
   endtask

   initial begin
      logic [127:0] d;
      int n;
      reset = 1'b1; cmd_en = 1'b0; cmd_instr = '0; cmd_bl = '0; cmd_byte_addr = '0;
      wr_en = 1'b0; wr_mask = '0; wr_data = '0; rd_en = 1'b0;
      repeat (3) tick();

      check("rst_calib_done", calib_done, 1'b0);
      check("rst_cmd_empty", cmd_empty, 1'b1);
      check("rst_wr_empty", wr_empty, 1'b1);
      check("rst_rd_empty", rd_empty, 1'b1);
      check("rst_rd_data", rd_data, '0);
      check("rst_flags", {wr_underrun, wr_error, rd_overflow, rd_error}, 4'b0000);
      reset = 1'b0;
      wait_calib("calib_cycles");

      // 1: 16-word burst round trip, plus a refresh that must be a no-op
      for (int k = 0; k < 16; k++) begin
         d = {16{8'(k)}};
         push_wr(d, 16'h0000);
      end
      check("t1_wr_count", wr_count, 7'd16);
      send_cmd(MCB_WR, 15, 30'h100);
      apply_write(16, 15);
      wait_wr_done();
      send_cmd(3'b100, 7, 30'h100);
      repeat (10) tick();
      check("t1_refresh_noread", rd_count, 7'd0);
      expect_read(16, 15);
      send_cmd(MCB_RD, 15, 30'h100);
      drain("t1_burst_data");
      check("t1_flags", {wr_error, rd_error, wr_underrun, rd_overflow}, 4'b0000);

      // 2: byte-masked overwrite of word 0
      for (int b = 0; b < 16; b++) d[b*8 +: 8] = 8'(b);
      push_wr(d, 16'h0000);
      send_cmd(MCB_WR, 0, baddr_of(0));
      apply_write(0, 0);
      wait_wr_done();
      push_wr('1, 16'h00FF);
      send_cmd(MCB_WR, 0, baddr_of(0));
      apply_write(0, 0);
      wait_wr_done();
      send_cmd(MCB_RD, 0, baddr_of(0));
      pop_one_const();

      // 3: burst wrapping past the top of the array, read back word by word
      for (int k = 0; k < 4; k++) push_wr({4{32'hA5A5_0000 + 32'(k)}}, 16'h0000);
      send_cmd(3'b010, 3, baddr_of(1022));
      apply_write(1022, 3);
      wait_wr_done();
      expect_read(1022, 0); send_cmd(MCB_RD, 0, baddr_of(1022));
      expect_read(1023, 0); send_cmd(3'b011, 0, baddr_of(1023));
      expect_read(0, 0);    send_cmd(MCB_RD, 0, 30'h2000_0000);
      expect_read(1, 0);    send_cmd(MCB_RD, 0, baddr_of(1));
      drain("t3_wrap_data");

      // 4: read of empty FIFO, then a write burst starved of data
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("t4_rd_error", rd_error, 1'b1);
      check("t4_rd_count", rd_count, 7'd0);
      send_cmd(MCB_WR, 3, baddr_of(64));
      push_wr(128'h1111, 16'h0000);
      push_wr(128'h2222, 16'h0000);
      repeat (10) tick();
      check("t4_wr_underrun", wr_underrun, 1'b1);
      check("t4_wr_count", wr_count, 7'd0);
      push_wr(128'h3333, 16'h0000);
      push_wr(128'h4444, 16'h0000);
      apply_write(64, 3);
      wait_wr_done();
      expect_read(64, 3);
      send_cmd(MCB_RD, 3, baddr_of(64));
      drain("t4_underrun_data");

      // 5: read held in RWAIT until the rd FIFO has room for the whole burst
      for (int k = 0; k < 4; k++) begin
         expect_read(16, 14);
         send_cmd(MCB_RD, 14, baddr_of(16));
      end
      n = 0;
      while (rd_count != 7'd60 && n < 500) begin
         tick();
         n++;
      end
      check("t5_fill60", rd_count, 7'd60);
      expect_read(16, 7);
      send_cmd(MCB_RD, 7, baddr_of(16));
      repeat (20) tick();
      check("t5_hold_60", rd_count, 7'd60);
      for (int k = 0; k < 3; k++) pop_one("t5_pop_data");
      repeat (10) tick();
      check("t5_hold_57", rd_count, 7'd57);
      pop_one("t5_pop_data");
      n = 0;
      while (rd_count != 7'd64 && n < 500) begin
         tick();
         n++;
      end
      check("t5_count64", rd_count, 7'd64);
      check("t5_rd_full", rd_full, 1'b1);
      check("t5_rd_overflow", rd_overflow, 1'b0);
      drain("t5_burst_data");

      // 5b: wr FIFO full boundary and a maximum-length burst
      for (int k = 0; k < 64; k++) push_wr({4{32'(k * 7 + 3)}}, 16'(k));
      check("t5b_wr_count", wr_count, 7'd64);
      check("t5b_wr_full", wr_full, 1'b1);
      wr_en = 1'b1; wr_data = '1; wr_mask = '0;
      tick();
      wr_en = 1'b0;
      check("t5b_wr_error", wr_error, 1'b1);
      check("t5b_wr_count_drop", wr_count, 7'd64);
      send_cmd(MCB_WR, 63, baddr_of(512));
      apply_write(512, 63);
      wait_wr_done();
      expect_read(512, 63);
      send_cmd(MCB_RD, 63, baddr_of(512));
      drain("t5b_bl63_data");
      check("t5b_rd_overflow", rd_overflow, 1'b0);

      // 6: reset in the middle of a read burst
      send_cmd(MCB_RD, 15, 30'h100);
      n = 0;
      while (rd_count < 7'd5 && n < 500) begin
         tick();
         n++;
      end
      check("t6_reached_word5", rd_count >= 7'd5, 1'b1);
      reset = 1'b1;
      #2;
      exp_q.delete();
      wr_pend.delete();
      check("t6_rst_flags", {wr_underrun, wr_error, rd_overflow, rd_error}, 4'b0000);
      check("t6_rst_rd_count", rd_count, 7'd0);
      check("t6_rst_rd_data", rd_data, '0);
      check("t6_rst_calib", calib_done, 1'b0);
      check("t6_rst_cmd_empty", cmd_empty, 1'b1);
      repeat (2) tick();
      reset = 1'b0;
      wait_calib("t6_calib_cycles");
      check("t6_cmd_empty", cmd_empty, 1'b1);
      expect_read(16, 0);
      send_cmd(MCB_RD, 0, 30'h100);
      drain("t6_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // masked-write result as a fixed constant in addition to the model
   task automatic pop_one_const();
      logic [127:0] want;
      want = 128'hFFFF_FFFF_FFFF_FFFF_0706_0504_0302_0100;
      exp_q.push_back(want);
      check("t2_model_agrees", model[0], want);
      pop_one("t2_masked_data");
   endtask

endmodule
